wb_arbiter_rr: RTL and testbench
================================

// Module: wb_arbiter_rr
// PURPOSE
//   Two-master, one-slave Wishbone classic arbiter with round-robin fairness and a bus watchdog.
//   Sits between the picorv32_wb master (port 0) and a second master such as a DMA or debug
//   loader (port 1), in front of the shared on-chip wb_ram.
//   Ownership is held for the whole cyc assertion, so multi-beat/RMW sequences stay atomic.
//   A slave that never acks is aborted with an error to the owning master.
// PARAMETERS
//   AW       32   address width
//   DW       32   data width (byte selects = DW/8)
//   TIMEOUT  256  stb-without-ack cycles before abort; 0 disables the watchdog
// PORTS
//   wb_clk_i  in   1        clock; all logic on rising edge
//   wb_rst_i  in   1        synchronous reset, active high
//   m_adr_i   in   2*AW     master addresses, {m1,m0}
//   m_dat_i   in   2*DW     master write data, {m1,m0}
//   m_sel_i   in   2*DW/8   master byte selects, {m1,m0}
//   m_we_i    in   2        master write enables
//   m_cyc_i   in   2        master cycle requests
//   m_stb_i   in   2        master strobes
//   m_dat_o   out  DW       read data, s_dat_i broadcast to both masters
//   m_ack_o   out  2        per-master ack
//   m_err_o   out  2        per-master watchdog error, 1-cycle pulse
//   s_adr_o   out  AW       slave address
//   s_dat_o   out  DW       slave write data
//   s_sel_o   out  DW/8     slave byte selects
//   s_we_o    out  1        slave write enable
//   s_cyc_o   out  1        slave cycle
//   s_stb_o   out  1        slave strobe
//   s_dat_i   in   DW       slave read data
//   s_ack_i   in   1        slave ack
//   grant_o   out  2        registered one-hot owner; 00 when idle
// BEHAVIOUR
// - FSM states IDLE, OWN, ABORT. Registers: grant_o, last (last owner), wd_cnt.
// - Reset (sync, wins over everything):
//   - State and grant: IDLE, grant_o=00, last=1 (m0 wins the first contest), wd_cnt=0.
//   - Outputs: all s_* outputs 0, m_ack_o=00, m_err_o=00.
// - IDLE:
//   - No m_cyc_i: stay in IDLE.
//   - One m_cyc_i: grant that master; go to OWN on the next edge.
//   - Both m_cyc_i: grant the master != last.
//   - Latency: s_cyc_o rises exactly 1 cycle after the first m_cyc_i seen in IDLE.
// - OWN(i):
//   - s_adr/dat/sel/we/stb_o = master i's inputs (combinational mux).
//   - s_cyc_o = m_cyc_i[i].
//   - m_ack_o[i] = s_ack_i; the other ack is 0.
//   - The other master's requests are ignored; it waits with its signals held.
//   - When m_cyc_i[i]=0 at an edge: go to IDLE, last=i, grant_o=00. This gives at least one
//     idle cycle between owners.
// - Watchdog (TIMEOUT>0):
//   - wd_cnt increments each OWN cycle with s_stb_o=1 and s_ack_i=0.
//   - wd_cnt clears on s_ack_i, on stb low, and on leaving OWN.
//   - wd_cnt==TIMEOUT-1 with no ack: m_err_o[i]=1 for that cycle; go to ABORT.
// - ABORT(i):
//   - s_cyc_o=s_stb_o=0; s_ack_i is ignored (a late ack never reaches a master).
//   - Stay until m_cyc_i[i]=0, then go to IDLE, last=i.
// - Idle outputs: in IDLE all s_* outputs are 0 and m_ack_o=m_err_o=00.
// - Boundary cases:
//   - Ack and cyc drop in the same cycle: the ack is delivered, then IDLE.
//   - Ack on the timeout cycle: the ack wins; no err is raised.
//   - Reset mid-transfer: abandon the transfer with no ack or err; s_cyc_o is 0 after the edge.
// - The design is compatible with slaves that assert ack every other cycle while stb is held.
// TESTING
// 1. m0 reads 0x0000_0100, m1 idle -> grant_o=01 and s_cyc_o=1 one cycle after m0_cyc;
//    only m_ack_o[0] pulses; m_dat_o=mem word.
// 2. Both cyc high after reset, 4 back-to-back single transfers each ->
//    owners m0,m1,m0,m1,... with one idle cycle between owners.
// 3. m0 holds cyc over 3 stb beats (adr 0x10,0x14,0x18); m1 requests at beat 1 ->
//    m1 gets no s_cyc_o until the cycle after m0 drops cyc.
// 4. TIMEOUT=16, slave ack tied 0, m1 owner -> m_err_o[1] pulses on stb cycle 16;
//    s_cyc_o=0 next cycle; grant held until m1 drops cyc.
// 5. m1 writes 123456789 to 0x2000_0000, sel=1111 -> s_adr/dat/sel/we_o match exactly;
//    m_ack_o=10.
// 6. wb_rst_i pulsed during m0's stb -> all outputs 0 after the edge, grant_o=00;
//    the next contest grants m0.

Source files
------------

// File: rtl/wb_arb_if.sv
// Bus bundle for the two-master / one-slave Wishbone arbiter.
// master modport: the environment side (masters drive requests, slave drives
//                 read data and ack).
// slave modport:  the arbiter side (takes requests, drives the slave bus,
//                 acks, errors and the grant).
// Master-side vectors are packed {m1,m0}.
interface wb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [2*AW-1:0]   m_adr_i;
  logic [2*DW-1:0]   m_dat_i;
  logic [2*DW/8-1:0] m_sel_i;
  logic [1:0]        m_we_i;
  logic [1:0]        m_cyc_i;
  logic [1:0]        m_stb_i;
  logic [DW-1:0]     m_dat_o;
  logic [1:0]        m_ack_o;
  logic [1:0]        m_err_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic              s_we_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i;
  logic [1:0]        grant_o;

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o,
           s_cyc_o, s_stb_o, grant_o
  );

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i, s_dat_i, s_ack_i,
    output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o,
           s_cyc_o, s_stb_o, grant_o
  );
endinterface

// File: rtl/wb_arbiter_rr.sv
// Two-master, one-slave Wishbone classic arbiter with round-robin fairness
// and a stb-without-ack watchdog.
// Ports:
//   wb_clk_i  clock, rising edge
//   wb_rst_i  synchronous reset, active high
//   bus       wb_arb_if.slave: master requests {m1,m0}, slave bus, per-master
//             ack/err, registered one-hot grant_o (00 when idle)
// Ownership lasts for the owner's whole cyc assertion so multi-beat and RMW
// sequences stay atomic. On a watchdog expiry the owner gets a one-cycle
// err and the slave bus is parked until the owner drops cyc.
module wb_arbiter_rr #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input logic   wb_clk_i,
  input logic   wb_rst_i,
  wb_arb_if.slave bus
);
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;

  state_t         state;
  logic [1:0]     grant;
  logic           last;
  logic [WDW-1:0] wd_cnt;

  logic            own;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat;
  logic [DW/8-1:0] s_sel;
  logic            s_we, s_cyc, s_stb;
  logic [1:0]      m_ack, m_err;
  logic            wd_hit;

  // grant is one-hot while owned, so bit 1 is the owner index
  assign own = grant[1];

  always_comb begin
    s_adr  = '0;
    s_dat  = '0;
    s_sel  = '0;
    s_we   = 1'b0;
    s_cyc  = 1'b0;
    s_stb  = 1'b0;
    m_ack  = 2'b00;
    m_err  = 2'b00;
    wd_hit = 1'b0;
    if (state == OWN) begin
      s_adr = own ? bus.m_adr_i[2*AW-1:AW]     : bus.m_adr_i[AW-1:0];
      s_dat = own ? bus.m_dat_i[2*DW-1:DW]     : bus.m_dat_i[DW-1:0];
      s_sel = own ? bus.m_sel_i[2*DW/8-1:DW/8] : bus.m_sel_i[DW/8-1:0];
      s_we  = bus.m_we_i[own];
      s_cyc = bus.m_cyc_i[own];
      s_stb = bus.m_stb_i[own];
      m_ack[own] = bus.s_ack_i;
      // an ack on the last allowed cycle wins over the timeout
      wd_hit = (TIMEOUT != 0) && s_cyc && s_stb && !bus.s_ack_i &&
               (wd_cnt == WDW'(TIMEOUT - 1));
      m_err[own] = wd_hit;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= IDLE;
      grant  <= 2'b00;
      last   <= 1'b1;       // m0 wins the first contest
      wd_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (bus.m_cyc_i[0] && (!bus.m_cyc_i[1] || last)) begin
            grant <= 2'b01;
            state <= OWN;
          end else if (bus.m_cyc_i[1]) begin
            grant <= 2'b10;
            state <= OWN;
          end
        end
        OWN: begin
          if (!bus.m_cyc_i[own]) begin
            state  <= IDLE;
            grant  <= 2'b00;
            last   <= own;
            wd_cnt <= '0;
          end else if (wd_hit) begin
            state  <= ABORT;
            wd_cnt <= '0;
          end else if ((TIMEOUT != 0) && s_stb && !bus.s_ack_i) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        ABORT: begin
          // slave bus stays parked; a late ack is dropped here
          if (!bus.m_cyc_i[own]) begin
            state <= IDLE;
            grant <= 2'b00;
            last  <= own;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  assign bus.s_adr_o = s_adr;
  assign bus.s_dat_o = s_dat;
  assign bus.s_sel_o = s_sel;
  assign bus.s_we_o  = s_we;
  assign bus.s_cyc_o = s_cyc;
  assign bus.s_stb_o = s_stb;
  assign bus.m_ack_o = m_ack;
  assign bus.m_err_o = m_err;
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant;
endmodule

// File: tb/tb_wb_arbiter_rr.sv
module tb_wb_arbiter_rr;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] D0   = 32'hA5A5_0000;
  localparam logic [31:0] D1   = 32'd123456789;
  localparam logic [3:0]  SEL0 = 4'b0011;
  localparam logic [3:0]  SEL1 = 4'b1111;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_arb_if #(.AW(AW), .DW(DW)) bus ();

  wb_arbiter_rr #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic        ack;
    logic [31:0] adr0, adr1;
    logic [1:0]  e_grant;
    logic        e_scyc, e_sstb, e_bus;
    logic [1:0]  e_ack, e_err;
  } vec_t;

  vec_t vt[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic r, logic [1:0] c, logic [1:0] s, logic [1:0] w,
                              logic a, logic [31:0] a0, logic [31:0] a1,
                              logic [1:0] eg, logic ec, logic es, logic eb,
                              logic [1:0] ea, logic [1:0] ee);
    vec_t v;
    v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.ack = a; v.adr0 = a0; v.adr1 = a1;
    v.e_grant = eg; v.e_scyc = ec; v.e_sstb = es; v.e_bus = eb; v.e_ack = ea; v.e_err = ee;
    return v;
  endfunction

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(logic r, logic [1:0] c, logic [1:0] s, logic [1:0] w, logic a,
                       logic [31:0] a0, logic [31:0] a1);
    rst = r;
    bus.m_cyc_i = c; bus.m_stb_i = s; bus.m_we_i = w; bus.s_ack_i = a;
    bus.m_adr_i = {a1, a0};
  endtask

  // {grant, s_cyc, s_stb, m_ack, m_err}
  function automatic logic [7:0] ctl();
    return {bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o};
  endfunction

  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h2000_0000;

  initial begin
    logic [127:0] act, exp;
    logic         o;
    bus.m_dat_i = {D1, D0};
    bus.m_sel_i = {SEL1, SEL0};
    bus.s_dat_i = '0;
    drive(1, 2'b00, 2'b00, 2'b00, 0, A0, A1);
    repeat (2) @(negedge clk);

    // rst cyc stb we ack adr0 adr1 | grant scyc sstb bus ack err
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00)); // reset state
    // m0 read, m1 idle
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,A0,A1, 2'b01,1,1,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b01,2'b01,2'b00,1,A0,A1, 2'b01,1,1,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b01,0,0,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    // m1 write 123456789 to 0x2000_0000
    vt.push_back(mk(0,2'b10,2'b10,2'b10,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b10,1,A0,A1, 2'b10,1,1,1,2'b10,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b10,0,0,1,2'b00,2'b00));
    // both request: alternate owners with an idle cycle between
    vt.push_back(mk(0,2'b11,2'b11,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,1,A0,A1, 2'b01,1,1,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b00,0,A0,A1, 2'b01,0,0,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,1,A0,A1, 2'b10,1,1,1,2'b10,2'b00));
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,A0,A1, 2'b10,0,0,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b01,2'b01,2'b00,1,A0,A1, 2'b01,1,1,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b01,0,0,1,2'b00,2'b00));
    // m0 holds cyc over 3 beats, m1 waits
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,32'h10,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,1,32'h10,A1, 2'b01,1,1,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,0,32'h14,A1, 2'b01,1,1,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,1,32'h14,A1, 2'b01,1,1,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,1,32'h18,A1, 2'b01,1,1,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b00,0,32'h18,A1, 2'b01,0,0,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b00,0,32'h18,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b00,1,32'h18,A1, 2'b10,1,1,1,2'b10,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b10,0,0,1,2'b00,2'b00));
    // ack and cyc drop together: ack still delivered
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,1,A0,A1, 2'b01,0,0,1,2'b01,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    // reset mid-transfer; next contest goes to m0 although m0 owned last
    vt.push_back(mk(0,2'b01,2'b01,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(1,2'b01,2'b01,2'b00,0,A0,A1, 2'b01,1,1,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,1,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b11,2'b11,2'b00,0,A0,A1, 2'b01,1,1,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b00,0,A0,A1, 2'b01,0,0,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b10,2'b10,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b10,0,0,1,2'b00,2'b00));
    vt.push_back(mk(0,2'b00,2'b00,2'b00,0,A0,A1, 2'b00,0,0,0,2'b00,2'b00));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].rst, vt[i].cyc, vt[i].stb, vt[i].we, vt[i].ack, vt[i].adr0, vt[i].adr1);
      bus.s_dat_i = 32'hD000_0000 + i;
      #1;
      o = vt[i].e_grant[1];
      act = {bus.grant_o, bus.s_cyc_o, bus.s_stb_o, bus.m_ack_o, bus.m_err_o,
             bus.s_we_o, bus.s_sel_o, bus.s_adr_o, bus.s_dat_o, bus.m_dat_o};
      exp = {vt[i].e_grant, vt[i].e_scyc, vt[i].e_sstb, vt[i].e_ack, vt[i].e_err,
             vt[i].e_bus ? vt[i].we[o] : 1'b0,
             vt[i].e_bus ? (o ? SEL1 : SEL0) : 4'b0,
             vt[i].e_bus ? (o ? vt[i].adr1 : vt[i].adr0) : 32'h0,
             vt[i].e_bus ? (o ? D1 : D0) : 32'h0,
             32'hD000_0000 + i};
      check($sformatf("vec%0d", i), act, exp);
    end

    // watchdog: m1 owner, slave never acks
    @(negedge clk); drive(0, 2'b10, 2'b10, 2'b00, 0, A0, A1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      check($sformatf("wd_stb%0d", k), {120'b0, ctl()},
            {120'b0, 2'b10, 1'b1, 1'b1, 2'b00, (k == 16) ? 2'b10 : 2'b00});
    end
    // abort: bus parked, late ack dropped, grant held
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); bus.s_ack_i = 1'b1; #1;
      check($sformatf("abort%0d", k), {120'b0, ctl()}, {120'b0, 8'b10_0_0_00_00});
    end
    @(negedge clk); drive(0, 2'b00, 2'b00, 2'b00, 0, A0, A1); #1;
    check("abort_drop", {120'b0, ctl()}, {120'b0, 8'b10_0_0_00_00});
    @(negedge clk); #1;
    check("abort_idle", {120'b0, ctl()}, {120'b0, 8'b00_0_0_00_00});

    // ack on the timeout cycle wins
    drive(0, 2'b10, 2'b10, 2'b00, 0, A0, A1);
    repeat (16) @(negedge clk);
    bus.s_ack_i = 1'b1; #1;
    check("ack_on_timeout", {120'b0, ctl()}, {120'b0, 8'b10_1_1_10_00});
    @(negedge clk); bus.s_ack_i = 1'b0; #1;
    check("after_ack_own", {120'b0, ctl()}, {120'b0, 8'b10_1_1_00_00});
    @(negedge clk); drive(0, 2'b00, 2'b00, 2'b00, 0, A0, A1);
    @(negedge clk); #1;
    check("final_idle", {120'b0, ctl()}, {120'b0, 8'b00_0_0_00_00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
